// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the integer register file: round-robin between ALU and LSU,
// registered write port, and a busy scoreboard of destinations with writes in flight.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P = 5,
    parameter int DEPTH_P      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_alu_valid,
    input  logic [ADDR_WIDTH_P-1:0] i_alu_addr,
    input  logic [DATA_WIDTH_P-1:0] i_alu_data,
    output logic                    o_alu_ready,
    input  logic                    i_lsu_valid,
    input  logic [ADDR_WIDTH_P-1:0] i_lsu_addr,
    input  logic [DATA_WIDTH_P-1:0] i_lsu_data,
    output logic                    o_lsu_ready,
    input  logic                    i_hold,
    input  logic                    i_rsv_valid,
    input  logic [ADDR_WIDTH_P-1:0] i_rsv_addr,
    output logic                    o_wr_enable,
    output logic [ADDR_WIDTH_P-1:0] o_wr_addr,
    output logic [DATA_WIDTH_P-1:0] o_wr_data,
    output logic [DEPTH_P-1:0]      o_busy
);

    logic               last_grant;   // 0 = ALU granted most recently, 1 = LSU
    logic               grant_alu;
    logic               grant_lsu;
    logic [DEPTH_P-1:0] busy;
    logic [DEPTH_P-1:0] busy_next;

    // Arbitration: a lone requester wins; under contention the one not granted last wins.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (!reset && !i_hold) begin
            if (i_alu_valid && (!i_lsu_valid || last_grant)) begin
                grant_alu = 1'b1;
            end else if (i_lsu_valid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    assign o_alu_ready = grant_alu;
    assign o_lsu_ready = grant_lsu;

    // Set is applied after clear so a fresh reservation survives the retiring write.
    always_comb begin
        busy_next = busy;
        if (o_wr_enable) begin
            busy_next[o_wr_addr] = 1'b0;
        end
        if (i_rsv_valid && (i_rsv_addr != '0)) begin
            busy_next[i_rsv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= 1'b1;
            o_wr_enable <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            busy        <= '0;
        end else begin
            busy <= busy_next;
            if (grant_alu) begin
                last_grant  <= 1'b0;
                o_wr_addr   <= i_alu_addr;
                o_wr_data   <= i_alu_data;
                o_wr_enable <= (i_alu_addr != '0);
            end else if (grant_lsu) begin
                last_grant  <= 1'b1;
                o_wr_addr   <= i_lsu_addr;
                o_wr_data   <= i_lsu_data;
                o_wr_enable <= (i_lsu_addr != '0);
            end else begin
                o_wr_enable <= 1'b0;
            end
        end
    end

    assign o_busy = busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios followed by randomized traffic.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_alu_valid = 1'b0;
    logic [4:0]  i_alu_addr = '0;
    logic [31:0] i_alu_data = '0;
    logic        o_alu_ready;
    logic        i_lsu_valid = 1'b0;
    logic [4:0]  i_lsu_addr = '0;
    logic [31:0] i_lsu_data = '0;
    logic        o_lsu_ready;
    logic        i_hold = 1'b0;
    logic        i_rsv_valid = 1'b0;
    logic [4:0]  i_rsv_addr = '0;
    logic        o_wr_enable;
    logic [4:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic [31:0] o_busy;

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .i_alu_valid(i_alu_valid), .i_alu_addr(i_alu_addr), .i_alu_data(i_alu_data),
        .o_alu_ready(o_alu_ready),
        .i_lsu_valid(i_lsu_valid), .i_lsu_addr(i_lsu_addr), .i_lsu_data(i_lsu_data),
        .o_lsu_ready(o_lsu_ready),
        .i_hold(i_hold), .i_rsv_valid(i_rsv_valid), .i_rsv_addr(i_rsv_addr),
        .o_wr_enable(o_wr_enable), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic alu_r;
        logic lsu_r;
    } rdy_t;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] busy;
    } out_t;

    rdy_t rdy_q[$];
    out_t out_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: who won last, what the write port holds, which regs are pending.
    int          m_last = 1;            // 0 = ALU, 1 = LSU
    logic        m_en = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    bit          m_busy[32];
    logic        g_alu, g_lsu;          // model's grant decision for the current cycle

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_busy();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // One cycle: drive inputs, let the model decide, queue the expected responses.
    task automatic step(input bit rst, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit lv, input logic [4:0] la, input logic [31:0] ld,
                        input bit hold, input bit rv, input logic [4:0] ra);
        rdy_t r;
        out_t o;
        int   winner;                   // -1 none, 0 ALU, 1 LSU
        @(negedge clk);
        reset = rst; i_hold = hold;
        i_alu_valid = av; i_alu_addr = aa; i_alu_data = ad;
        i_lsu_valid = lv; i_lsu_addr = la; i_lsu_data = ld;
        i_rsv_valid = rv; i_rsv_addr = ra;
        winner = -1;
        if (!rst && !hold) begin
            if (av && lv)  winner = (m_last == 1) ? 0 : 1;
            else if (av)   winner = 0;
            else if (lv)   winner = 1;
        end
        g_alu = (winner == 0);
        g_lsu = (winner == 1);
        r.alu_r = g_alu;
        r.lsu_r = g_lsu;
        rdy_q.push_back(r);
        if (rst) begin
            m_last = 1; m_en = 1'b0; m_addr = '0; m_data = '0;
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (m_en) m_busy[m_addr] = 1'b0;
            if (rv && ra != 0) m_busy[ra] = 1'b1;
            if (winner == 0) begin
                m_addr = aa; m_data = ad; m_en = (aa != 0); m_last = 0;
            end else if (winner == 1) begin
                m_addr = la; m_data = ld; m_en = (la != 0); m_last = 1;
            end else begin
                m_en = 1'b0;
            end
        end
        o.en = m_en; o.addr = m_addr; o.data = m_data; o.busy = pack_busy();
        out_q.push_back(o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Ready monitor: combinational readies sampled mid-cycle after inputs settle.
    always @(negedge clk) begin
        #2;
        if (rdy_q.size() > 0) begin
            rdy_t r;
            r = rdy_q.pop_front();
            chk("alu_ready", {31'b0, o_alu_ready}, {31'b0, r.alu_r});
            chk("lsu_ready", {31'b0, o_lsu_ready}, {31'b0, r.lsu_r});
        end
    end

    // Write-port / scoreboard monitor: registered outputs sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (out_q.size() > 0) begin
            out_t o;
            o = out_q.pop_front();
            chk("wr_enable", {31'b0, o_wr_enable}, {31'b0, o.en});
            chk("wr_addr", {27'b0, o_wr_addr}, {27'b0, o.addr});
            chk("wr_data", o_wr_data, o.data);
            chk("busy", o_busy, o.busy);
        end
    end

    initial begin
        bit          ap, lp;
        logic [4:0]  aa, la;
        logic [31:0] ad, ld;

        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        do_reset();

        // Single ALU write
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Continuous contention after reset: ALU, LSU, ALU, LSU
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 1, 1, 32'h100 + i, 1, 2, 32'h200 + i, 0, 0, 0);
        idle(1);

        // Write to x0 completes the handshake but never writes
        step(0, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0);
        idle(2);

        // Reserve 7, write 7, busy drops two cycles after the grant
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        step(0, 1, 7, 32'h77, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Second run: re-reservation in T+1 keeps the bit set
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        step(0, 1, 7, 32'h78, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        idle(2);

        // Hold blocks grants; release gives ALU first after reset
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 9, 32'h9, 1, 10, 32'hA, 1, 0, 0);
        step(0, 1, 9, 32'h9, 1, 10, 32'hA, 0, 0, 0);
        step(0, 0, 0, 0, 1, 10, 32'hA, 0, 0, 0);
        idle(1);

        // Reset mid-flight discards the registered write and all busy bits
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        step(0, 1, 3, 32'h33, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Randomized traffic; producers keep requests stable until accepted
        ap = 0; lp = 0; aa = '0; la = '0; ad = '0; ld = '0;
        for (int c = 0; c < 400; c++) begin
            bit rst, hold, rv;
            logic [4:0] ra;
            rst  = ($urandom_range(0, 99) < 2);
            hold = ($urandom_range(0, 99) < 15);
            rv   = ($urandom_range(0, 99) < 40);
            ra   = 5'($urandom_range(0, 31));
            if (rst) begin
                ap = 0; lp = 0;
            end else begin
                if (!ap && $urandom_range(0, 99) < 60) begin
                    ap = 1; aa = 5'($urandom_range(0, 31)); ad = $urandom;
                end
                if (!lp && $urandom_range(0, 99) < 60) begin
                    lp = 1; la = 5'($urandom_range(0, 31)); ld = $urandom;
                end
            end
            step(rst, ap, aa, ad, lp, la, ld, hold, rv, ra);
            if (g_alu) ap = 0;
            if (g_lsu) lp = 0;
        end
        idle(3);

        for (int i = 0; i < 10 && (rdy_q.size() > 0 || out_q.size() > 0); i++) @(posedge clk);
        #3;
        if (rdy_q.size() > 0 || out_q.size() > 0) begin
            chk("drain", 32'(rdy_q.size() + out_q.size()), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
